// File: rtl/io_arb_pkg.sv
// Shared types and constants for the input-side device arbiter.
// Also provides a one-hot helper that future output-side arbitration can reuse.
package io_arb_pkg;

  localparam int N_DEV  = 4;
  localparam int DATA_W = 32;
  localparam int WAIT_W = 16;

  typedef logic [1:0] dev_idx_t;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  function automatic logic [N_DEV-1:0] dev_onehot(input dev_idx_t idx);
    logic [N_DEV-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/io_arbiter_rr_picker.sv
// Combinational round-robin picker: the first set request bit after `last`, with wrap.
// `last` itself is checked at the lowest priority.
module rr_picker
  import io_arb_pkg::*;
(
  input  logic [N_DEV-1:0] req,
  input  dev_idx_t         last,
  output logic             valid,
  output dev_idx_t         winner
);

  dev_idx_t idx;

  // Scan from the farthest offset down, so the nearest requester is written last and wins.
  always_comb begin
    valid  = 1'b0;
    winner = last;
    idx    = '0;
    for (int i = N_DEV; i >= 1; i--) begin
      idx = last + dev_idx_t'(i[1:0]);
      if (req[idx]) begin
        valid  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/io_arbiter.sv
// Input-side arbiter: grants one pending device to the processor's input port
// and holds the captured word until the processor acknowledges it.
module io_arbiter
  import io_arb_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_DEV*DATA_W-1:0] dev_in,
  input  logic [N_DEV-1:0]        enter_in,
  output logic [N_DEV-1:0]        dev_ack,
  input  logic                    in_req,
  input  logic                    in_sel_en,
  input  dev_idx_t                in_sel,
  output logic                    in_ready,
  input  logic                    in_ack,
  output logic [DATA_W-1:0]       in_data,
  output dev_idx_t                in_dev,
  output logic                    busy,
  output logic [WAIT_W-1:0]       wait_cycles,
  output state_t                  dbg_state
);

  // Handshakes: a device holds enter_in until its one-cycle dev_ack pulse; the
  // processor's word is valid while in_ready=1 and is consumed on an edge with in_ack=1.

  state_t   state, next_state;
  dev_idx_t last;
  logic     pick_valid;
  dev_idx_t pick_idx;
  logic     eligible;
  dev_idx_t grant_idx;
  logic     grant;

  rr_picker u_rr_picker (
    .req    (enter_in),
    .last   (last),
    .valid  (pick_valid),
    .winner (pick_idx)
  );

  always_comb begin
    eligible  = 1'b0;
    grant_idx = '0;
    if (in_sel_en) begin
      eligible  = enter_in[in_sel];
      grant_idx = in_sel;
    end else begin
      eligible  = pick_valid;
      grant_idx = pick_idx;
    end
  end

  assign grant = (state == IDLE) && in_req && eligible;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (grant)  next_state = PRESENT;
      PRESENT: if (in_ack) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == PRESENT);
    busy      = (state == PRESENT);
    dbg_state = state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dev_ack     <= '0;
      in_data     <= '0;
      in_dev      <= '0;
      last        <= dev_idx_t'(N_DEV - 1);
      wait_cycles <= '0;
    end else begin
      dev_ack <= '0;
      if (grant) begin
        in_data     <= dev_in[DATA_W*int'(grant_idx) +: DATA_W];
        in_dev      <= grant_idx;
        dev_ack     <= dev_onehot(grant_idx);
        last        <= grant_idx;
        wait_cycles <= '0;
      end else if ((state == IDLE) && in_req && (wait_cycles != {WAIT_W{1'b1}})) begin
        wait_cycles <= wait_cycles + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_io_arbiter.sv
// Self-checking bench for io_arbiter: table-driven grants plus hand-written
// multi-cycle sequences, with captured words checked through an expected queue.
module tb_io_arbiter;
  import io_arb_pkg::*;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [N_DEV*DATA_W-1:0] dev_in;
  logic [N_DEV-1:0]        enter_in;
  logic [N_DEV-1:0]        dev_ack;
  logic                    in_req;
  logic                    in_sel_en;
  logic [1:0]              in_sel;
  logic                    in_ready;
  logic                    in_ack;
  logic [DATA_W-1:0]       in_data;
  logic [1:0]              in_dev;
  logic                    busy;
  logic [WAIT_W-1:0]       wait_cycles;
  state_t                  dbg_state;

  logic [DATA_W-1:0] dev_word [N_DEV];
  assign dev_in = {dev_word[3], dev_word[2], dev_word[1], dev_word[0]};

  io_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .dev_in      (dev_in),
    .enter_in    (enter_in),
    .dev_ack     (dev_ack),
    .in_req      (in_req),
    .in_sel_en   (in_sel_en),
    .in_sel      (in_sel),
    .in_ready    (in_ready),
    .in_ack      (in_ack),
    .in_data     (in_data),
    .in_dev      (in_dev),
    .busy        (busy),
    .wait_cycles (wait_cycles),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DATA_W+1:0] exp_q[$];

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1; enter_in = '0; in_req = 1'b0; in_ack = 1'b0;
    in_sel_en = 1'b0; in_sel = '0;
    step(2);
    rst = 1'b0;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic expect_word(input logic [1:0] idx);
    exp_q.push_back({idx, dev_word[idx]});
  endtask

  task automatic check_word(input string name);
    logic [DATA_W+1:0] e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: word presented with empty expected queue", name);
    end else begin
      e = exp_q.pop_front();
      n_checks--;
      check({name, "_dev"}, 64'(in_dev), 64'(e[DATA_W+1:DATA_W]));
      check({name, "_data"}, 64'(in_data), 64'(e[DATA_W-1:0]));
    end
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_ready"}, 64'(in_ready), 64'd0);
    check({name, "_busy"}, 64'(busy), 64'd0);
    check({name, "_ack"}, 64'(dev_ack), 64'd0);
    check({name, "_data"}, 64'(in_data), 64'd0);
    check({name, "_dev"}, 64'(in_dev), 64'd0);
    check({name, "_wait"}, 64'(wait_cycles), 64'd0);
    check({name, "_state"}, 64'(dbg_state), 64'(IDLE));
  endtask

  // ---------------- driver: one full grant/consume transaction ----------------
  task automatic do_grant(input string name, input logic [3:0] enter,
                          input logic sel_en, input logic [1:0] sel, input logic [1:0] exp_dev);
    for (int d = 0; d < N_DEV; d++) dev_word[d] = $urandom();
    enter_in = enter; in_sel_en = sel_en; in_sel = sel; in_req = 1'b1; in_ack = 1'b0;
    expect_word(exp_dev);
    step();
    check({name, "_ready"}, 64'(in_ready), 64'd1);
    check({name, "_ack"}, 64'(dev_ack), 64'(dev_onehot(exp_dev)));
    check_word(name);
    enter_in[exp_dev] = 1'b0;
    step();
    check({name, "_ack_pulse"}, 64'(dev_ack), 64'd0);
    check({name, "_hold"}, 64'(in_ready), 64'd1);
    in_ack = 1'b1;
    step();
    check({name, "_release"}, 64'(in_ready), 64'd0);
    in_ack = 1'b0; in_req = 1'b0; enter_in = '0;
  endtask

  typedef struct {
    logic [3:0] enter;
    logic       sel_en;
    logic [1:0] sel;
    logic [1:0] exp_dev;
  } vec_t;

  vec_t vecs [9];

  initial begin
    logic [1:0] order [5];

    // Expected winners derived by hand from the round-robin pointer, starting at last=3.
    vecs[0] = '{4'b1010, 1'b0, 2'd0, 2'd1};
    vecs[1] = '{4'b1010, 1'b0, 2'd0, 2'd3};
    vecs[2] = '{4'b1111, 1'b0, 2'd0, 2'd0};
    vecs[3] = '{4'b1111, 1'b0, 2'd0, 2'd1};
    vecs[4] = '{4'b0001, 1'b0, 2'd0, 2'd0};
    vecs[5] = '{4'b1111, 1'b1, 2'd2, 2'd2};
    vecs[6] = '{4'b0110, 1'b0, 2'd0, 2'd1};
    vecs[7] = '{4'b1000, 1'b1, 2'd3, 2'd3};
    vecs[8] = '{4'b0101, 1'b0, 2'd0, 2'd0};

    for (int d = 0; d < N_DEV; d++) dev_word[d] = '0;
    apply_reset();
    check_idle_outputs("reset");

    for (int v = 0; v < 9; v++) do_grant($sformatf("vec%0d", v), vecs[v].enter,
                                         vecs[v].sel_en, vecs[v].sel, vecs[v].exp_dev);

    // Back-to-back with in_ack tied high: one word every 2 cycles, order 0,1,2,3,0.
    apply_reset();
    order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    for (int d = 0; d < N_DEV; d++) dev_word[d] = $urandom();
    for (int g = 0; g < 5; g++) expect_word(order[g]);
    enter_in = 4'b1111; in_req = 1'b1; in_ack = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      check($sformatf("b2b_ready%0d", k), 64'(in_ready), 64'(k % 2));
      if (k % 2 == 1) begin
        check($sformatf("b2b_ack%0d", k), 64'(dev_ack), 64'(dev_onehot(order[(k-1)/2])));
        check_word($sformatf("b2b%0d", k));
      end else begin
        check($sformatf("b2b_ack%0d", k), 64'(dev_ack), 64'd0);
      end
    end
    in_ack = 1'b0; in_req = 1'b0; enter_in = '0;
    step();

    // Selected mode waits on device 2 even though device 0 is pending.
    apply_reset();
    in_sel_en = 1'b1; in_sel = 2'd2; enter_in = 4'b0001; in_req = 1'b1;
    step(10);
    check("sel_wait", 64'(wait_cycles), 64'd10);
    check("sel_no_grant", 64'(in_ready), 64'd0);
    enter_in = 4'b0101;
    expect_word(2'd2);
    step();
    check("sel_grant_ready", 64'(in_ready), 64'd1);
    check_word("sel_grant");
    check("sel_wait_clr", 64'(wait_cycles), 64'd0);
    enter_in = 4'b0001; in_ack = 1'b1;
    step();
    in_ack = 1'b0; in_sel_en = 1'b0;

    // Word held after in_req drops, until in_ack (pointer now 2, device 0 wins).
    dev_word[0] = 32'hDEADBEEF;
    enter_in = 4'b0001; in_req = 1'b1;
    step();
    enter_in = '0; in_req = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("hold_ready%0d", k), 64'(in_ready), 64'd1);
      check($sformatf("hold_data%0d", k), 64'(in_data), 64'hDEADBEEF);
      step();
    end
    in_ack = 1'b1;
    step();
    check("hold_release", 64'(in_ready), 64'd0);
    in_ack = 1'b0;

    // Reset while presenting discards the word; reset also beats a grant condition.
    enter_in = 4'b0010; in_req = 1'b1;
    step();
    check("pre_rst_present", 64'(in_ready), 64'd1);
    rst = 1'b1; enter_in = 4'b1111;
    step();
    check_idle_outputs("rst_present");
    step();
    check_idle_outputs("rst_vs_grant");
    rst = 1'b0;
    for (int d = 0; d < N_DEV; d++) dev_word[d] = $urandom();
    expect_word(2'd0);
    step();
    check("post_rst_ack", 64'(dev_ack), 64'(dev_onehot(2'd0)));
    check_word("post_rst");
    in_req = 1'b0; enter_in = '0; in_ack = 1'b1;
    step();
    in_ack = 1'b0;

    // Starvation counter saturation.
    apply_reset();
    in_req = 1'b1;
    step(65534);
    check("wait_near_max", 64'(wait_cycles), 64'hFFFE);
    step(4466);
    check("wait_saturate", 64'(wait_cycles), 64'hFFFF);
    in_req = 1'b0;
    step(3);
    check("wait_hold", 64'(wait_cycles), 64'hFFFF);

    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/io_arbiter.md
# io_arbiter

Input-side device arbiter between the four 32-bit device channels and the processor's single input-instruction port. Devices post words on `dev_in` with `enter_in`; when the processor executes an input instruction (`in_req`), the arbiter picks one pending device, either round-robin or a processor-selected one. It captures the word, acknowledges the device, and holds the word for the processor until it is consumed. It sits between the device inputs and the processor's input port in the machine top level.

## Interface
- `N_DEV`, 4, number of device channels (fixed at 4 in this revision)
- `DATA_W`, 32, width of one device word
- `WAIT_W`, 16, width of the starvation counter

- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `dev_in`  in  128  device i word at bits [32i+31:32i]
- `enter_in`  in  4  device i has a word pending; level, held until its `dev_ack` pulse
- `dev_ack`  out  4  one-cycle pulse, word from device i captured
- `in_req`  in  1  processor wants an input word; level
- `in_sel_en`  in  1  1 = serve only device `in_sel`; 0 = round-robin
- `in_sel`  in  2  target device when `in_sel_en`=1
- `in_ready`  out  1  `in_data`/`in_dev` valid
- `in_ack`  in  1  processor consumed word; honoured only while `in_ready`=1
- `in_data`  out  32  captured word
- `in_dev`  out  2  index of the device that supplied `in_data`
- `busy`  out  1  word held, i.e. `in_ready`
- `wait_cycles`  out  16  cycles spent waiting with `in_req`=1 and no eligible device; saturating

## Operation
- States: IDLE, PRESENT.
- In IDLE, a grant occurs when `in_req`=1 and an eligible device exists:
  - Selected mode: eligible = `enter_in[in_sel]`.
  - Round-robin mode: eligible = any `enter_in` bit. The winner is the first set bit scanning from `(last+1) mod 4` upward with wrap.
- On a grant edge:
  - latch `dev_in` slice into `in_data` and the index into `in_dev`
  - set `dev_ack[g]`=1 for exactly that next cycle
  - set `last` <= g
  - clear `wait_cycles`
  - go to PRESENT.
- In IDLE with `in_req`=1 and no eligible device, `wait_cycles` increments and saturates at 0xFFFF. It holds its value when `in_req`=0.
- Selected mode with `enter_in[in_sel]`=0: no grant, even if other devices are pending. `wait_cycles` counts.
- In PRESENT, `in_ready`=1. `in_data`/`in_dev` are stable. Mode inputs and `enter_in` are ignored.
- `in_ack`=1 in PRESENT returns to IDLE and `in_ready` drops at the next edge.
- `in_req` dropping during PRESENT does not discard the word. It stays presented until `in_ack`, because the device has already been acked.
- The device must drop `enter_in[g]` the cycle after its `dev_ack` pulse. A re-raised `enter_in` is treated as a new word. No grant is possible before the return to IDLE, so there is no double capture.
- Reset values:
  - `in_ready`, `busy`, `dev_ack`, `in_data`, `in_dev`, `wait_cycles` = 0
  - state IDLE
  - `last`=3, so device 0 has first priority.
- Reset mid-PRESENT discards the held word, which is lost to the system; this is documented and accepted. Reset in the same cycle as a grant condition wins and no `dev_ack` is issued.

## Timing
- Grant latency: `in_req` and `enter_in[i]` both high at edge n → `in_ready`=1, `dev_ack[i]`=1 after edge n, i.e. visible in cycle n+1.
- `dev_ack` is a registered one-cycle pulse, at most one bit set.
- Release: `in_ack` high at edge m → `in_ready`=0 after m. The earliest next grant is edge m+1.
- Throughput: at most one word per 2 cycles (back-to-back when `in_ack` is tied high).
- All outputs registered. No combinational path from inputs to outputs.

## Structure
- Package `io_arb_pkg`: state enum (IDLE, PRESENT), `N_DEV`, `DATA_W`, `WAIT_W`, device index type.
- Sub-module `rr_picker`: combinational. Inputs are the 4-bit request vector and a 2-bit `last` pointer. Outputs are a valid flag and a 2-bit winner index. It is reused by future output-side arbitration.
- The top contains the FSM, data/index registers, the ack pulse register and the wait counter.

## Test plan
- After reset, `enter_in`=4'b1010 and `in_req`=1 → device 1 granted, `dev_ack`=4'b0010 for one cycle, `in_data`=`dev_in[63:32]`, `in_dev`=1. `in_ack` → next grant is device 3.
- All four `enter_in` held high, `in_req` and `in_ack` high continuously → grant order 0,1,2,3,0; one word every 2 cycles.
- `in_sel_en`=1, `in_sel`=2, `enter_in`=4'b0001 for 10 cycles → no grant, `wait_cycles`=10. Raising bit 2 → device 2 granted, `wait_cycles`=0.
- Grant device 0 with `dev_in[31:0]`=0xDEADBEEF, then drop `in_req` and hold `in_ack`=0 for 5 cycles → `in_ready`=1 and `in_data`=0xDEADBEEF throughout. `in_ack` → `in_ready`=0 next cycle.
- `rst` asserted while in PRESENT → next cycle all outputs 0 and IDLE. With `enter_in`=4'b1111 the subsequent grant goes to device 0.
- `in_req`=1 with no `enter_in` held for 70000 cycles → `wait_cycles` saturates at 0xFFFF.
